// File: rtl/axi_bridge_mp.sv
// axi_bridge_mp: NPORT SRAM-like ports onto one AXI3 master with round-robin grants, per-port read tracking and one in-flight write.
module axi_bridge_mp #(
   parameter int NPORT          = 2,
   parameter int RD_OUTSTANDING = 2,
   parameter int ID_W           = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NPORT-1:0]     sram_req,
   input  logic [NPORT-1:0]     sram_wr,
   input  logic [2*NPORT-1:0]   sram_size,
   input  logic [32*NPORT-1:0]  sram_addr,
   input  logic [4*NPORT-1:0]   sram_wstrb,
   input  logic [32*NPORT-1:0]  sram_wdata,
   output logic [NPORT-1:0]     sram_addr_ok,
   output logic [NPORT-1:0]     sram_data_ok,
   output logic [32*NPORT-1:0]  sram_rdata,
   output logic [ID_W-1:0]      arid,
   output logic [31:0]          araddr,
   output logic [2:0]           arsize,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic [ID_W-1:0]      rid,
   input  logic [31:0]          rdata,
   input  logic                 rvalid,
   output logic                 rready,
   output logic [ID_W-1:0]      awid,
   output logic [31:0]          awaddr,
   output logic [2:0]           awsize,
   output logic                 awvalid,
   input  logic                 awready,
   output logic [31:0]          wdata,
   output logic [3:0]           wstrb,
   output logic                 wvalid,
   input  logic                 wready,
   input  logic [ID_W-1:0]      bid,
   input  logic                 bvalid,
   output logic                 bready
);
   localparam int PW = NPORT > 1 ? $clog2(NPORT) : 1;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wst_t;
   wst_t             wst_q, wst_d;
   logic             ready_q, ready_d;
   logic             ar_valid_q, ar_valid_d;
   logic [ID_W-1:0]  ar_id_q, ar_id_d;
   logic [31:0]      ar_addr_q, ar_addr_d;
   logic [2:0]       ar_size_q, ar_size_d;
   logic [2:0]       rd_cnt_q [NPORT];
   logic [2:0]       rd_cnt_d [NPORT];
   logic             aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
   logic [ID_W-1:0]  w_id_q, w_id_d;
   logic [31:0]      w_addr_q, w_addr_d, w_data_q, w_data_d;
   logic [2:0]       w_size_q, w_size_d;
   logic [3:0]       w_strb_q, w_strb_d;
   logic [PW-1:0]    rr_q, rr_d, gnt;
   logic [NPORT-1:0] elig;
   logic             gnt_vld, gnt_rd, gnt_wr, r_fire, b_fire;
   assign arid       = ar_id_q;
   assign araddr     = ar_addr_q;
   assign arsize     = ar_size_q;
   assign arvalid    = ar_valid_q;
   assign awid       = w_id_q;
   assign awaddr     = w_addr_q;
   assign awsize     = w_size_q;
   assign awvalid    = aw_valid_q;
   assign wdata      = w_data_q;
   assign wstrb      = w_strb_q;
   assign wvalid     = w_valid_q;
   assign rready     = ready_q;
   assign bready     = ready_q;
   assign sram_rdata = {NPORT{rdata}};
   always_comb begin
      elig = '0;
      // a read waits behind any pending write from its own port or to the same word
      for (int i = 0; i < NPORT; i++)
         elig[i] = resetn && sram_req[i] && (sram_wr[i] ? (wst_q == W_IDLE && rd_cnt_q[i] == 3'd0)
            : (int'(rd_cnt_q[i]) < RD_OUTSTANDING && !ar_valid_q
               && !(wst_q != W_IDLE && (w_id_q == ID_W'(i) || sram_addr[32*i+2 +: 30] == w_addr_q[31:2]))));
      gnt_vld = 1'b0;
      gnt     = '0;
      for (int k = 0; k < NPORT; k++)
         if (!gnt_vld && elig[(int'(rr_q) + k) % NPORT]) begin
            gnt_vld = 1'b1;
            gnt     = PW'((int'(rr_q) + k) % NPORT);
         end
      gnt_rd = gnt_vld && !sram_wr[gnt];
      gnt_wr = gnt_vld && sram_wr[gnt];
      r_fire = ready_q && rvalid;
      b_fire = ready_q && bvalid && wst_q == W_RESP && bid == w_id_q;
      for (int i = 0; i < NPORT; i++) begin
         sram_addr_ok[i] = gnt_vld && gnt == PW'(i);
         sram_data_ok[i] = (r_fire && rid == ID_W'(i)) || (b_fire && w_id_q == ID_W'(i));
         rd_cnt_d[i]     = rd_cnt_q[i] + {2'b0, gnt_rd && gnt == PW'(i)} - {2'b0, r_fire && rid == ID_W'(i)};
      end
      ready_d    = 1'b1;
      rr_d       = gnt_vld ? (gnt == PW'(NPORT - 1) ? '0 : gnt + 1'b1) : rr_q;
      ar_valid_d = gnt_rd || (ar_valid_q && !arready);
      ar_id_d    = gnt_rd ? ID_W'(gnt) : ar_id_q;
      ar_addr_d  = gnt_rd ? sram_addr[32*int'(gnt) +: 32] : ar_addr_q;
      ar_size_d  = gnt_rd ? {1'b0, sram_size[2*int'(gnt) +: 2]} : ar_size_q;
      wst_d      = wst_q;
      aw_valid_d = aw_valid_q && !awready;
      w_valid_d  = w_valid_q && !wready;
      w_id_d     = w_id_q;
      w_addr_d   = w_addr_q;
      w_size_d   = w_size_q;
      w_strb_d   = w_strb_q;
      w_data_d   = w_data_q;
      case (wst_q)
         W_IDLE: if (gnt_wr) begin
            w_id_d     = ID_W'(gnt);
            w_addr_d   = sram_addr[32*int'(gnt) +: 32];
            w_size_d   = {1'b0, sram_size[2*int'(gnt) +: 2]};
            w_strb_d   = sram_wstrb[4*int'(gnt) +: 4];
            w_data_d   = sram_wdata[32*int'(gnt) +: 32];
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            wst_d      = W_SEND;
         end
         W_SEND: wst_d = (!aw_valid_d && !w_valid_d) ? W_RESP : W_SEND;
         W_RESP: wst_d = b_fire ? W_IDLE : W_RESP;
         default: wst_d = W_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wst_q      <= W_IDLE;
         ready_q    <= 1'b0;
         rr_q       <= '0;
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_size_q  <= '0;
         rd_cnt_q   <= '{default: '0};
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         w_id_q     <= '0;
         w_addr_q   <= '0;
         w_size_q   <= '0;
         w_strb_q   <= '0;
         w_data_q   <= '0;
      end else begin
         wst_q      <= wst_d;
         ready_q    <= ready_d;
         rr_q       <= rr_d;
         ar_valid_q <= ar_valid_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_size_q  <= ar_size_d;
         rd_cnt_q   <= rd_cnt_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         w_id_q     <= w_id_d;
         w_addr_q   <= w_addr_d;
         w_size_q   <= w_size_d;
         w_strb_q   <= w_strb_d;
         w_data_q   <= w_data_d;
      end
   end
endmodule

// File: tb/tb_axi_bridge_mp.sv
// tb_axi_bridge_mp: scoreboard bench with a small AXI slave model for axi_bridge_mp.
module tb_axi_bridge_mp;
   localparam int NP = 2;
   localparam int IW = 4;
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] exp;
   } item_t;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;
   logic [NP-1:0]    sram_req, sram_wr, sram_addr_ok, sram_data_ok;
   logic [2*NP-1:0]  sram_size;
   logic [32*NP-1:0] sram_addr, sram_wdata, sram_rdata;
   logic [4*NP-1:0]  sram_wstrb;
   logic [IW-1:0]    arid, rid, awid, bid;
   logic [31:0]      araddr, rdata, awaddr, wdata;
   logic [2:0]       arsize, awsize;
   logic [3:0]       wstrb;
   logic             arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   item_t            pq [NP][$];
   item_t            sb [NP][$];
   logic [37:0]      arq [$];
   logic [35:0]      rq [$];
   int               gseq [$];
   logic [31:0]      smem [logic [29:0]];
   int               n_chk = 0, n_pass = 0, wok = 0, aw_lat = 0, aw_seen = 0, aw_cyc = 0, w_cyc = 0;
   logic             raw_done = 1'b0, r_en = 1'b0;
   logic             aw_got, w_got;
   logic [IW-1:0]    b_id;
   logic [31:0]      b_addr, b_data;
   logic [3:0]       b_strb;
   assign arready = 1'b1;
   assign wready  = 1'b1;
   assign awready = aw_seen > aw_lat;
   axi_bridge_mp #(.NPORT(NP), .RD_OUTSTANDING(2), .ID_W(IW)) dut (
      .clk(clk), .resetn(resetn),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
      .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bvalid(bvalid), .bready(bready)
   );
   function automatic logic [31:0] pat(input logic [31:0] a);
      return {16'hBEEF ^ a[17:2], a[17:2]};
   endfunction
   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return smem.exists(a[31:2]) ? smem[a[31:2]] : pat(a);
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction
   function automatic item_t mk(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] exp);
      item_t it;
      it.wr = wr; it.addr = addr; it.size = size; it.wstrb = strb; it.wdata = wd; it.exp = exp;
      return it;
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // one cycle: present each port's head request, record grants at negedge
   task automatic step();
      item_t it;
      for (int p = 0; p < NP; p++) begin
         if (pq[p].size() > 0) begin
            it = pq[p][0];
            sram_req[p] = 1'b1;
            sram_wr[p] = it.wr;
            sram_size[2*p +: 2] = it.size;
            sram_addr[32*p +: 32] = it.addr;
            sram_wstrb[4*p +: 4] = it.wstrb;
            sram_wdata[32*p +: 32] = it.wdata;
         end else sram_req[p] = 1'b0;
      end
      @(negedge clk);
      if (sram_addr_ok != '0) chk("addr_ok_onehot", $onehot(sram_addr_ok), 1);
      for (int p = 0; p < NP; p++)
         if (sram_addr_ok[p]) begin
            chk($sformatf("grant_has_req%0d", p), pq[p].size() > 0, 1);
            if (pq[p].size() > 0) begin
               it = pq[p].pop_front();
               sb[p].push_back(it);
               gseq.push_back(p);
               if (!it.wr) arq.push_back({it.size, 4'(p), it.addr});
            end
         end
      @(posedge clk);
      #1;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((pq[0].size() + pq[1].size() + sb[0].size() + sb[1].size()) > 0 && n < 300) begin
         step();
         n++;
      end
      chk("drain_done", n < 300, 1);
   endtask
   // scoreboard side: responses and AR issue order
   always @(negedge clk) begin
      item_t       it;
      logic [37:0] e;
      if (awvalid) aw_cyc <= aw_cyc + 1;
      if (wvalid) w_cyc <= w_cyc + 1;
      aw_seen <= awvalid ? aw_seen + 1 : 0;
      if (resetn) begin
         for (int p = 0; p < NP; p++)
            if (sram_data_ok[p]) begin
               chk($sformatf("data_ok_expected%0d", p), sb[p].size() > 0, 1);
               if (sb[p].size() > 0) begin
                  it = sb[p].pop_front();
                  if (it.wr) begin
                     wok++;
                     if (p == 1) raw_done = 1'b1;
                  end else chk($sformatf("rdata%0d", p), sram_rdata[32*p +: 32], it.exp);
               end
            end
         if (arvalid && arready) begin
            chk("ar_expected", arq.size() > 0, 1);
            if (arq.size() > 0) begin
               e = arq.pop_front();
               chk("arid", arid, e[35:32]);
               chk("araddr", araddr, e[31:0]);
               chk("arsize", arsize, {1'b0, e[37:36]});
               if (araddr == 32'h2006) chk("raw_after_b", raw_done, 1);
            end
         end
      end
   end
   always @(posedge clk) begin
      logic [35:0] e;
      if (!resetn) begin
         rq.delete();
         rvalid <= 1'b0;
         bvalid <= 1'b0;
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else begin
         if (arvalid && arready) rq.push_back({arid, araddr});
         if (rvalid && rready) rvalid <= 1'b0;
         if (r_en && rq.size() > 0 && (!rvalid || rready)) begin
            e = rq.pop_front();
            rid    <= e[35:32];
            rdata  <= rd_word(e[31:0]);
            rvalid <= 1'b1;
         end
         if (awvalid && awready) begin
            aw_got <= 1'b1;
            b_id   <= awid;
            b_addr <= awaddr;
         end
         if (wvalid && wready) begin
            w_got  <= 1'b1;
            b_data <= wdata;
            b_strb <= wstrb;
         end
         if (aw_got && w_got && !bvalid) begin
            smem[b_addr[31:2]] = merge(rd_word(b_addr), b_data, b_strb);
            bid    <= b_id;
            bvalid <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] t;
      int          a0, w0, k0;
      resetn = 1'b0;
      sram_req = '0; sram_wr = '0; sram_size = '0; sram_addr = '0; sram_wstrb = '0; sram_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rready", rready, 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rready_first_cycle", rready, 0);
      @(negedge clk);
      chk("rready_after", rready, 1);
      chk("bready_after", bready, 1);
      chk("idle_outputs", {arvalid, awvalid, wvalid, sram_addr_ok, sram_data_ok}, 0);
      @(posedge clk);
      #1;
      r_en = 1'b0;
      for (int i = 0; i < 3; i++) pq[0].push_back(mk(0, 32'h1000 + 4 * i, 2'd2, 0, 0, pat(32'h1000 + 4 * i)));
      repeat (6) step();
      chk("third_read_stalled", pq[0].size(), 1);
      r_en = 1'b1;
      drain();
      gseq.delete();
      for (int i = 0; i < 4; i++) begin
         pq[0].push_back(mk(0, 32'h1100 + 4 * i, 2'd2, 0, 0, pat(32'h1100 + 4 * i)));
         pq[1].push_back(mk(0, 32'h1200 + 4 * i, 2'd1, 0, 0, pat(32'h1200 + 4 * i)));
      end
      drain();
      chk("rr_grant_count", gseq.size(), 8);
      for (int k = 1; k < gseq.size(); k++) chk($sformatf("rr_alt%0d", k), gseq[k] != gseq[k-1], 1);
      pq[1].push_back(mk(1, 32'h2004, 2'd1, 4'b0011, 32'h1234ABCD, 0));
      step();
      t = pat(32'h2004);
      pq[0].push_back(mk(0, 32'h2006, 2'd1, 0, 0, {t[31:16], 16'hABCD}));
      drain();
      chk("raw_done_seen", raw_done, 1);
      aw_lat = 3;
      a0 = aw_cyc; w0 = w_cyc; k0 = wok;
      pq[0].push_back(mk(1, 32'h2100, 2'd2, 4'hF, 32'hCAFEF00D, 0));
      drain();
      chk("awvalid_cycles", aw_cyc - a0, 4);
      chk("wvalid_cycles", w_cyc - w0, 1);
      chk("wr_ok_once", wok - k0, 1);
      aw_lat = 0;
      pq[1].push_back(mk(0, 32'h2100, 2'd2, 0, 0, 32'hCAFEF00D));
      drain();
      aw_lat = 10;
      pq[0].push_back(mk(1, 32'h2200, 2'd2, 4'hF, 32'h55AA55AA, 0));
      repeat (3) step();
      chk("pre_rst_awvalid", awvalid, 1);
      chk("pre_rst_wvalid", wvalid, 0);
      resetn = 1'b0;
      sram_req = '0;
      pq[0].delete(); pq[1].delete(); sb[0].delete(); sb[1].delete(); arq.delete();
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_outputs", {arvalid, awvalid, wvalid, sram_addr_ok, sram_data_ok, rready, bready}, 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      aw_lat = 0;
      @(negedge clk);
      chk("rel_rready_first", rready, 0);
      @(negedge clk);
      chk("rel_rready_after", rready, 1);
      @(posedge clk);
      #1;
      pq[0].push_back(mk(0, 32'h3000, 2'd2, 0, 0, pat(32'h3000)));
      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
